// File: rtl/adaptive_binarizer.sv
// adaptive_binarizer: two-stage binarizer whose threshold is the midpoint of two online-learned centroids.
// Build option ATHR_MANUAL_THRESHOLD_EN adds i_manual_en/i_manual_thr to override the threshold per beat.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for first sof; beats ignored
//   ST_WARM | centroids train on each beat, no output beats
//   ST_RUN  | every beat trains and produces an output beat
module adaptive_binarizer #(
    parameter int PIX_W      = 8,
    parameter int NPIX       = 9,
    parameter int LR_SHIFT   = 3,
    parameter int U1_INIT    = 100,
    parameter int U2_INIT    = 120,
    parameter int WARM_BEATS = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NPIX*PIX_W-1:0] i_pixel_data,
    input  logic                  i_pixel_data_valid,
    input  logic                  i_sof,
    input  logic                  i_freeze,
`ifdef ATHR_MANUAL_THRESHOLD_EN
    input  logic                  i_manual_en,
    input  logic [PIX_W-1:0]      i_manual_thr,
`endif
    output logic [NPIX-1:0]       o_mask,
    output logic [PIX_W-1:0]      o_center_bin,
    output logic [PIX_W-1:0]      o_threshold,
    output logic                  o_data_valid
);

    localparam int ERR_W  = PIX_W + 2 + $clog2(NPIX);
    localparam int SUM_W  = ERR_W + 1;
    localparam int WCNT_W = (WARM_BEATS > 2) ? $clog2(WARM_BEATS) : 1;

    localparam logic [PIX_W-1:0]        U1_V      = PIX_W'(U1_INIT);
    localparam logic [PIX_W-1:0]        U2_V      = PIX_W'(U2_INIT);
    localparam logic [PIX_W:0]          RST_SUM   = {1'b0, U1_V} + {1'b0, U2_V};
    localparam logic [PIX_W-1:0]        RST_THR   = PIX_W'(RST_SUM >> 1);
    localparam logic [WCNT_W-1:0]       WCNT_LOAD = WCNT_W'((WARM_BEATS > 0) ? WARM_BEATS - 1 : 0);
    localparam logic signed [SUM_W-1:0] PIX_MAX   = SUM_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WCNT_W-1:0]        r_warm_cnt;
    logic [WCNT_W-1:0]        w_warm_cnt_nxt;
    logic                     w_accept;
    logic                     w_emit;

    logic                     r_s1_valid;
    logic                     r_s1_sof;
    logic                     r_s1_freeze;
    logic [NPIX*PIX_W-1:0]    r_s1_pix;
`ifdef ATHR_MANUAL_THRESHOLD_EN
    logic                     r_s1_man_en;
    logic [PIX_W-1:0]         r_s1_man_thr;
`endif

    logic [PIX_W-1:0]         r_u1;
    logic [PIX_W-1:0]         r_u2;
    logic [NPIX-1:0]          r_mask;
    logic [PIX_W-1:0]         r_center_bin;
    logic [PIX_W-1:0]         r_threshold;
    logic                     r_data_valid;

    logic [PIX_W-1:0]         w_base_u1;
    logic [PIX_W-1:0]         w_base_u2;
    logic [PIX_W:0]           w_thr_sum;
    logic [PIX_W-1:0]         w_thr_adapt;
    logic [PIX_W-1:0]         w_thr;
    logic [NPIX-1:0]          w_mask;
    logic signed [ERR_W-1:0]  w_err1;
    logic signed [ERR_W-1:0]  w_err2;
    logic signed [SUM_W-1:0]  w_raw1;
    logic signed [SUM_W-1:0]  w_raw2;
    logic [PIX_W-1:0]         w_new1;
    logic [PIX_W-1:0]         w_new2;
    logic [PIX_W-1:0]         w_upd_u1;
    logic [PIX_W-1:0]         w_upd_u2;

    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [SUM_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction

    // A sof beat trains from the reload values, not from the previous frame.
    assign w_base_u1   = r_s1_sof ? U1_V : r_u1;
    assign w_base_u2   = r_s1_sof ? U2_V : r_u2;
    assign w_thr_sum   = {1'b0, w_base_u1} + {1'b0, w_base_u2};
    assign w_thr_adapt = PIX_W'(w_thr_sum >> 1);

`ifdef ATHR_MANUAL_THRESHOLD_EN
    assign w_thr = r_s1_man_en ? r_s1_man_thr : w_thr_adapt;
`else
    assign w_thr = w_thr_adapt;
`endif

    always_comb begin
        logic [PIX_W-1:0] v_p;
        logic [PIX_W-1:0] v_d1;
        logic [PIX_W-1:0] v_d2;
        w_mask = '0;
        w_err1 = '0;
        w_err2 = '0;
        v_p    = '0;
        v_d1   = '0;
        v_d2   = '0;
        for (int k = 0; k < NPIX; k++) begin
            v_p       = r_s1_pix[k*PIX_W +: PIX_W];
            v_d1      = (v_p >= w_base_u1) ? v_p - w_base_u1 : w_base_u1 - v_p;
            v_d2      = (v_p >= w_base_u2) ? v_p - w_base_u2 : w_base_u2 - v_p;
            w_mask[k] = (v_p >= w_thr);
            if (v_d1 <= v_d2)
                w_err1 = w_err1 + ($signed(ERR_W'(v_p)) - $signed(ERR_W'(w_base_u1)));
            else
                w_err2 = w_err2 + ($signed(ERR_W'(v_p)) - $signed(ERR_W'(w_base_u2)));
        end
    end

    assign w_raw1   = $signed(SUM_W'(w_base_u1)) + SUM_W'(w_err1 >>> LR_SHIFT);
    assign w_raw2   = $signed(SUM_W'(w_base_u2)) + SUM_W'(w_err2 >>> LR_SHIFT);
    assign w_new1   = r_s1_freeze ? w_base_u1 : sat_pix(w_raw1);
    assign w_new2   = r_s1_freeze ? w_base_u2 : sat_pix(w_raw2);
    assign w_upd_u1 = (w_new1 > w_new2) ? w_new2 : w_new1;
    assign w_upd_u2 = (w_new1 > w_new2) ? w_new1 : w_new2;

    always_comb begin
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        w_accept       = 1'b0;
        w_emit         = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_s1_sof) begin
                        w_accept = 1'b1;
                        if (WARM_BEATS > 0) begin
                            w_state_nxt    = (WARM_BEATS == 1) ? ST_RUN : ST_WARM;
                            w_warm_cnt_nxt = WCNT_LOAD;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_emit      = 1'b1;
                        end
                    end
                end
                ST_WARM: begin
                    w_accept = 1'b1;
                    if (r_s1_sof) begin
                        w_state_nxt    = (WARM_BEATS == 1) ? ST_RUN : ST_WARM;
                        w_warm_cnt_nxt = WCNT_LOAD;
                    end else if (r_warm_cnt <= WCNT_W'(1)) begin
                        w_state_nxt    = ST_RUN;
                        w_warm_cnt_nxt = '0;
                    end else begin
                        w_warm_cnt_nxt = r_warm_cnt - WCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    w_accept = 1'b1;
                    if (r_s1_sof && (WARM_BEATS > 0)) begin
                        w_state_nxt    = (WARM_BEATS == 1) ? ST_RUN : ST_WARM;
                        w_warm_cnt_nxt = WCNT_LOAD;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_warm_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sof     <= 1'b0;
            r_s1_freeze  <= 1'b0;
            r_s1_pix     <= '0;
`ifdef ATHR_MANUAL_THRESHOLD_EN
            r_s1_man_en  <= 1'b0;
            r_s1_man_thr <= '0;
`endif
            r_u1         <= U1_V;
            r_u2         <= U2_V;
            r_mask       <= '0;
            r_center_bin <= '0;
            r_threshold  <= RST_THR;
            r_data_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_pixel_data_valid;
            if (i_pixel_data_valid) begin
                r_s1_sof     <= i_sof;
                r_s1_freeze  <= i_freeze;
                r_s1_pix     <= i_pixel_data;
`ifdef ATHR_MANUAL_THRESHOLD_EN
                r_s1_man_en  <= i_manual_en;
                r_s1_man_thr <= i_manual_thr;
`endif
            end
            if (w_accept) begin
                r_u1 <= w_upd_u1;
                r_u2 <= w_upd_u2;
            end
            r_data_valid <= w_emit;
            if (w_emit) begin
                r_mask       <= w_mask;
                r_center_bin <= {PIX_W{w_mask[NPIX/2]}};
                r_threshold  <= w_thr;
            end
        end
    end

    assign o_mask       = r_mask;
    assign o_center_bin = r_center_bin;
    assign o_threshold  = r_threshold;
    assign o_data_valid = r_data_valid;

endmodule

// File: tb/tb_adaptive_binarizer.sv
// Scoreboard bench for adaptive_binarizer: two instances (no warm-up, 3 warm beats) against a behavioural model.
// Build with ATHR_MANUAL_THRESHOLD_EN defined to also exercise the manual threshold ports.
module tb_adaptive_binarizer;

    localparam int W1 = 3;
    localparam int LR = 3;

    typedef struct {
        logic [8:0] mask;
        logic [7:0] thr;
        logic [7:0] cb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [71:0] pix = '0;
    logic        valid = 1'b0;
    logic        sof = 1'b0;
    logic        frz = 1'b0;
    logic        man_en = 1'b0;
    logic [7:0]  man_thr = '0;

    logic [8:0]  mask0, mask1;
    logic [7:0]  cb0, cb1, thr0, thr1;
    logic        dv0, dv1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out[2] = '{0, 0};

    exp_t q0[$];
    exp_t q1[$];
    int   m_mode[2];
    int   m_seen[2];
    int   m_u1[2];
    int   m_u2[2];

    always #5 clk = ~clk;

    adaptive_binarizer #(.WARM_BEATS(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(valid),
        .i_sof(sof), .i_freeze(frz),
`ifdef ATHR_MANUAL_THRESHOLD_EN
        .i_manual_en(man_en), .i_manual_thr(man_thr),
`endif
        .o_mask(mask0), .o_center_bin(cb0), .o_threshold(thr0), .o_data_valid(dv0)
    );

    adaptive_binarizer #(.WARM_BEATS(W1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(valid),
        .i_sof(sof), .i_freeze(frz),
`ifdef ATHR_MANUAL_THRESHOLD_EN
        .i_manual_en(man_en), .i_manual_thr(man_thr),
`endif
        .o_mask(mask1), .o_center_bin(cb1), .o_threshold(thr1), .o_data_valid(dv1)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_seen[i] = 0;
            m_u1[i]   = 100;
            m_u2[i]   = 120;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Mode 0 = waiting for sof, 1 = warm-up, 2 = running.
    function automatic void model_beat(int i, int w, logic [71:0] p, bit s, bit f, bit men, int mthr);
        bit   proc = 0;
        bit   emit = 0;
        int   b1, b2, thr, e1, e2, pv, d1, d2, n1, n2, t;
        exp_t x;
        case (m_mode[i])
            0: if (s) begin
                proc = 1;
                if (w > 0) begin m_mode[i] = (w == 1) ? 2 : 1; m_seen[i] = 1; end
                else begin m_mode[i] = 2; emit = 1; end
            end
            1: begin
                proc = 1;
                if (s) begin m_mode[i] = (w == 1) ? 2 : 1; m_seen[i] = 1; end
                else begin m_seen[i]++; if (m_seen[i] >= w) m_mode[i] = 2; end
            end
            default: begin
                proc = 1;
                if (s && w > 0) begin m_mode[i] = (w == 1) ? 2 : 1; m_seen[i] = 1; end
                else emit = 1;
            end
        endcase
        if (!proc) return;
        b1  = s ? 100 : m_u1[i];
        b2  = s ? 120 : m_u2[i];
        thr = men ? mthr : (b1 + b2) / 2;
        e1 = 0; e2 = 0;
        x.mask = '0;
        for (int k = 0; k < 9; k++) begin
            pv = int'(p[k*8 +: 8]);
            x.mask[k] = (pv >= thr);
            d1 = (pv > b1) ? pv - b1 : b1 - pv;
            d2 = (pv > b2) ? pv - b2 : b2 - pv;
            if (d1 <= d2) e1 += pv - b1;
            else          e2 += pv - b2;
        end
        n1 = f ? b1 : clamp(b1 + (e1 >>> LR));
        n2 = f ? b2 : clamp(b2 + (e2 >>> LR));
        if (n1 > n2) begin t = n1; n1 = n2; n2 = t; end
        m_u1[i] = n1;
        m_u2[i] = n2;
        if (emit) begin
            x.thr = 8'(thr);
            x.cb  = x.mask[4] ? 8'hFF : 8'h00;
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endfunction

    task automatic mon_pop(int i, logic [8:0] m, logic [7:0] t, logic [7:0] c);
        exp_t x;
        string tag;
        tag = (i == 0) ? "d0" : "d1";
        n_out[i]++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk({tag, " unexpected output beat"}, 1, 0);
            return;
        end
        x = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk({tag, " mask"}, 32'(m), 32'(x.mask));
        chk({tag, " threshold"}, 32'(t), 32'(x.thr));
        chk({tag, " center_bin"}, 32'(c), 32'(x.cb));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dv0) mon_pop(0, mask0, thr0, cb0);
            if (dv1) mon_pop(1, mask1, thr1, cb1);
        end
    end

    task automatic drive(logic [71:0] p, bit s, bit f, bit model_it);
        pix = p; valid = 1'b1; sof = s; frz = f;
        if (model_it) begin
            model_beat(0, 0,  p, s, f, man_en, int'(man_thr));
            model_beat(1, W1, p, s, f, man_en, int'(man_thr));
        end
        @(posedge clk); #1;
        valid = 1'b0; sof = 1'b0; frz = 1'b0;
    endtask

    task automatic dbeat(string tag, logic [7:0] v, bit s, bit f, logic [8:0] em, logic [7:0] et);
        logic [71:0] p;
        p = {9{v}};
        drive(p, s, f, 1);
        @(posedge clk); @(negedge clk);
        chk({tag, " valid"}, 32'(dv0), 1);
        chk({tag, " mask"}, 32'(mask0), 32'(em));
        chk({tag, " threshold"}, 32'(thr0), 32'(et));
        chk({tag, " center_bin"}, 32'(cb0), em[4] ? 32'hFF : 32'h0);
    endtask

    function automatic logic [71:0] rand_pix();
        logic [71:0] p;
        int sel, c1, c2, v;
        sel = $urandom_range(0, 4);
        c1  = $urandom_range(0, 255);
        c2  = $urandom_range(0, 255);
        p   = '0;
        for (int k = 0; k < 9; k++) begin
            case (sel)
                0: v = $urandom_range(0, 255);
                1: v = c1;
                2: v = clamp((($urandom_range(0, 1) == 1) ? c1 : c2) + $urandom_range(0, 16) - 8);
                3: v = (c1 < 128) ? 0 : 255;
                default: v = clamp(110 + $urandom_range(0, 20) - 10);
            endcase
            p[k*8 +: 8] = 8'(v);
        end
        return p;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset valid0", 32'(dv0), 0);
        chk("reset mask0", 32'(mask0), 0);
        chk("reset center0", 32'(cb0), 0);
        chk("reset threshold0", 32'(thr0), 110);
        chk("reset threshold1", 32'(thr1), 110);
        @(posedge clk); #1;
        rst = 1'b0;

        drive({9{8'd200}}, 0, 0, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle no-sof valid0", 32'(dv0), 0);
            chk("idle no-sof valid1", 32'(dv1), 0);
        end

        dbeat("sof200",     8'd200, 1, 0, 9'h1FF, 8'd110);
        dbeat("next200",    8'd200, 0, 0, 9'h1FF, 8'd155);
        dbeat("sof0",       8'd0,   1, 0, 9'h000, 8'd110);
        dbeat("next0",      8'd0,   0, 0, 9'h000, 8'd60);
        dbeat("sof110",     8'd110, 1, 0, 9'h1FF, 8'd110);
        dbeat("next110",    8'd110, 0, 0, 9'h000, 8'd115);
        dbeat("sof200frz",  8'd200, 1, 1, 9'h1FF, 8'd110);
        dbeat("after frz",  8'd200, 0, 0, 9'h1FF, 8'd110);
`ifdef ATHR_MANUAL_THRESHOLD_EN
        man_en = 1'b1; man_thr = 8'd50;
        dbeat("manual60",   8'd60,  1, 0, 9'h1FF, 8'd50);
        man_en = 1'b0; man_thr = 8'd0;
`endif

        drive({9{8'd200}}, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midreset valid0", 32'(dv0), 0);
        chk("midreset threshold0", 32'(thr0), 110);
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 1500; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            sof   = ($urandom_range(0, 9) == 0);
            frz   = ($urandom_range(0, 7) == 0);
            pix   = rand_pix();
`ifdef ATHR_MANUAL_THRESHOLD_EN
            man_en  = ($urandom_range(0, 3) == 0);
            man_thr = 8'($urandom_range(0, 255));
`endif
            if (valid) begin
                model_beat(0, 0,  pix, sof, frz, man_en, int'(man_thr));
                model_beat(1, W1, pix, sof, frz, man_en, int'(man_thr));
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; sof = 1'b0; frz = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain queue0", 32'(q0.size()), 0);
        chk("drain queue1", 32'(q1.size()), 0);
        chk("outputs seen0", 32'(n_out[0] > 20), 1);
        chk("outputs seen1", 32'(n_out[1] > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
